// File: rtl/fpu_add_align_if.sv
// Operand/result handshake bundle for fpu_add_align.
// Slave is the adder front end; master is the producer/consumer around it.
interface fpu_add_align_if;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        sub_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [33:0] add_o;
  logic        out_valid_o;
  logic        out_ready_i;

  modport slave (
    input  a_i, b_i, sub_i, in_valid_i, out_ready_i,
    output in_ready_o, add_o, out_valid_o
  );

  modport master (
    output a_i, b_i, sub_i, in_valid_i, out_ready_i,
    input  in_ready_o, add_o, out_valid_o
  );
endinterface

// File: rtl/fpu_add_align.sv
// Two-stage binary32 add/sub front end: exponent align, then significand add.
// Emits the unnormalized {sign, exp, carry, hidden, frac} word for fpu_norm.
module fpu_add_align (
  input logic            clk_i,
  input logic            rst_ni,
  fpu_add_align_if.slave bus
);

  logic adv1, adv2, in_fire;
  logic v1, v2;

  // Unpack, with subnormals flushed to a zero significand
  logic        s_a, s_b;
  logic [7:0]  exp_a, exp_b;
  logic [23:0] sig_a, sig_b;
  logic        spec_a, spec_b;

  always_comb begin
    s_a    = bus.a_i[31];
    s_b    = bus.b_i[31] ^ bus.sub_i;
    exp_a  = bus.a_i[30:23];
    exp_b  = bus.b_i[30:23];
    sig_a  = (exp_a == '0) ? '0 : {1'b1, bus.a_i[22:0]};
    sig_b  = (exp_b == '0) ? '0 : {1'b1, bus.b_i[22:0]};
    spec_a = (exp_a == '1);
    spec_b = (exp_b == '1);
  end

  // Stage 1 combinational: order by magnitude (tie keeps A large), then shift
  logic        a_ge_b;
  logic        sl_c, ss_c;
  logic [7:0]  expl_c, exps_c, d_c;
  logic [23:0] sigl_c, sigs_c, shifted_c;
  logic        spec_c;
  logic [33:0] spec_res_c;

  always_comb begin
    a_ge_b     = ({exp_a, sig_a} >= {exp_b, sig_b});
    sl_c       = a_ge_b ? s_a   : s_b;
    ss_c       = a_ge_b ? s_b   : s_a;
    expl_c     = a_ge_b ? exp_a : exp_b;
    exps_c     = a_ge_b ? exp_b : exp_a;
    sigl_c     = a_ge_b ? sig_a : sig_b;
    sigs_c     = a_ge_b ? sig_b : sig_a;
    d_c        = expl_c - exps_c;
    shifted_c  = (d_c >= 8'd24) ? '0 : (sigs_c >> d_c[4:0]);
    spec_c     = spec_a | spec_b;
    spec_res_c = {(spec_a ? s_a : s_b), 8'hFF, 25'h0};
  end

  // Handshake: a stage advances when its successor is empty or draining
  always_comb begin
    adv2           = ~v2 | bus.out_ready_i;
    adv1           = ~v1 | adv2;
    in_fire        = bus.in_valid_i & adv1;
    bus.in_ready_o = adv1;
  end

  logic        s1_sl, s1_ss, s1_spec;
  logic [7:0]  s1_exp;
  logic [23:0] s1_sigl, s1_sigs;
  logic [33:0] s1_spec_res;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1 <= 1'b0;
    end else if (adv1) begin
      v1 <= bus.in_valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      s1_sl       <= sl_c;
      s1_ss       <= ss_c;
      s1_exp      <= expl_c;
      s1_sigl     <= sigl_c;
      s1_sigs     <= shifted_c;
      s1_spec     <= s1_spec_next(spec_c);
      s1_spec_res <= spec_res_c;
    end
  end

  function automatic logic s1_spec_next(input logic s);
    return s;
  endfunction

  // Stage 2 combinational: magnitude add or subtract (L >= S, never negative)
  logic [24:0] m_c;
  logic [33:0] res_c;

  always_comb begin
    if (s1_sl == s1_ss) m_c = {1'b0, s1_sigl} + {1'b0, s1_sigs};
    else                m_c = {1'b0, s1_sigl} - {1'b0, s1_sigs};
    if (s1_spec)         res_c = s1_spec_res;
    else if (m_c == '0)  res_c = '0;
    else                 res_c = {s1_sl, s1_exp, m_c};
  end

  logic [33:0] add_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v2    <= 1'b0;
      add_q <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) add_q <= res_c;
    end
  end

  assign bus.add_o       = add_q;
  assign bus.out_valid_o = v2;

endmodule

// File: tb/tb_fpu_add_align.sv
// Directed bench for fpu_add_align: datapath vectors, throughput, stall, reset.
module tb_fpu_add_align;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpu_add_align_if bus();
  fpu_add_align dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  localparam int NV = 14;
  logic [31:0] va [NV] = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h3F800000,
                           32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000,
                           32'h3F800000, 32'hFF800000, 32'h00000001, 32'hBF800000,
                           32'h40000000, 32'h00000000};
  logic [31:0] vb [NV] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000,
                           32'h30800000, 32'h33800000, 32'h34000000, 32'h3F800000,
                           32'hFF800000, 32'h7F800000, 32'h3F800000, 32'hBFC00000,
                           32'hBF800000, 32'h80000000};
  logic        vs [NV] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [33:0] ve [NV] = '{34'h0_FF00_0000, 34'h0_FE40_0000, 34'h3_0040_0000, 34'h0,
                           34'h0_FE80_0000, 34'h0_FE80_0000, 34'h0_FE80_0001,
                           34'h1_FE00_0000, 34'h3_FE00_0000, 34'h3_FE00_0000,
                           34'h0_FE80_0000, 34'h2_FF40_0000, 34'h1_0040_0000, 34'h0};
  string       vn [NV] = '{"one_plus_one", "1p5_minus_1", "1_minus_2_swap", "cancel",
                           "shift_d30", "shift_d24", "shift_d23", "inf_a", "neg_inf_b",
                           "both_inf", "subnormal_flush", "neg_plus_neg", "mixed_sign",
                           "zero_plus_negzero"};

  task automatic drive_op(input int k);
    bus.a_i        = va[k];
    bus.b_i        = vb[k];
    bus.sub_i      = vs[k];
    bus.in_valid_i = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.a_i = '0; bus.b_i = '0; bus.sub_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.out_valid_o);
    else n_pass++;
    n_checks++;
    if (bus.add_o !== 34'h0) $display("FAIL reset_add: got %h expected 0", bus.add_o);
    else n_pass++;
    n_checks++;
    if (bus.in_ready_o !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready_o);
    else n_pass++;
  endtask

  task automatic test_datapath;
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      bus.out_ready_i = 1'b1;
      drive_op(k);
      #1;
      n_checks++;
      if (bus.in_ready_o !== 1'b1) $display("FAIL %s_in_ready: got %b expected 1", vn[k], bus.in_ready_o);
      else n_pass++;
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
      n_checks++;
      if (bus.out_valid_o !== 1'b0) $display("FAIL %s_early_valid: got %b expected 0", vn[k], bus.out_valid_o);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid_o !== 1'b1) $display("FAIL %s_valid: got %b expected 1", vn[k], bus.out_valid_o);
      else n_pass++;
      n_checks++;
      if (bus.add_o !== ve[k]) $display("FAIL %s_add: got %h expected %h", vn[k], bus.add_o, ve[k]);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        n_checks++;
        if (bus.out_valid_o !== 1'b1 || bus.add_o !== ve[k-2])
          $display("FAIL b2b_%0d: got v=%b %h expected v=1 %h", k - 2, bus.out_valid_o, bus.add_o, ve[k-2]);
        else n_pass++;
      end
      if (k < 5) drive_op(k);
      else bus.in_valid_i = 1'b0;
      #1;
      n_checks++;
      if (bus.in_ready_o !== 1'b1) $display("FAIL b2b_in_ready_%0d: got %b expected 1", k, bus.in_ready_o);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid_o !== 1'b0) $display("FAIL b2b_drain: got %b expected 0", bus.out_valid_o);
    else n_pass++;
  endtask

  task automatic test_stall_release;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    drive_op(0);
    #1;
    n_checks++;
    if (bus.in_ready_o !== 1'b1) $display("FAIL stall_accept0: got %b expected 1", bus.in_ready_o);
    else n_pass++;
    @(negedge clk);
    drive_op(1);
    #1;
    n_checks++;
    if (bus.in_ready_o !== 1'b1) $display("FAIL stall_accept1: got %b expected 1", bus.in_ready_o);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_op(2);
      #1;
      n_checks++;
      if (bus.in_ready_o !== 1'b0) $display("FAIL stall_full_%0d: got in_ready %b expected 0", c, bus.in_ready_o);
      else n_pass++;
      n_checks++;
      if (bus.out_valid_o !== 1'b1 || bus.add_o !== ve[0])
        $display("FAIL stall_hold_%0d: got v=%b %h expected v=1 %h", c, bus.out_valid_o, bus.add_o, ve[0]);
      else n_pass++;
    end
    // release with op2 still offered: consume and accept on the same edge
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready_o !== 1'b1) $display("FAIL release_in_ready: got %b expected 1", bus.in_ready_o);
    else n_pass++;
    for (int r = 1; r <= 2; r++) begin
      @(negedge clk);
      bus.in_valid_i = 1'b0;
      n_checks++;
      if (bus.out_valid_o !== 1'b1 || bus.add_o !== ve[r])
        $display("FAIL release_res%0d: got v=%b %h expected v=1 %h", r, bus.out_valid_o, bus.add_o, ve[r]);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid_o !== 1'b0) $display("FAIL release_drain: got %b expected 0", bus.out_valid_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stall;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    drive_op(1);
    @(negedge clk);
    drive_op(2);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.add_o !== ve[1])
      $display("FAIL prereset_stall: got v=%b %h expected v=1 %h", bus.out_valid_o, bus.add_o, ve[1]);
    else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid_o !== 1'b0) $display("FAIL midreset_valid: got %b expected 0", bus.out_valid_o);
    else n_pass++;
    n_checks++;
    if (bus.add_o !== 34'h0) $display("FAIL midreset_add: got %h expected 0", bus.add_o);
    else n_pass++;
    n_checks++;
    if (bus.in_ready_o !== 1'b1) $display("FAIL midreset_in_ready: got %b expected 1", bus.in_ready_o);
    else n_pass++;
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid_o !== 1'b0) $display("FAIL stale_after_reset_%0d: got %b expected 0", c, bus.out_valid_o);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_datapath();
    test_back_to_back();
    test_stall_release();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
